// File: rtl/regfile_op_sequencer.sv
// Register-file operation sequencer: reads two operands, runs a small ALU, writes back, responds.
// Optional macro REGSEQ_OVF_FLAG_EN adds the resp_ovf signed-overflow flag.
module regfile_op_sequencer #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_rs1,
  input  logic [ADDR_W-1:0] cmd_rs2,
  input  logic [ADDR_W-1:0] cmd_rd,
  output logic [ADDR_W-1:0] rf_read_addr1,
  output logic [ADDR_W-1:0] rf_read_addr2,
  input  logic [DATA_W-1:0] rf_read_data1,
  input  logic [DATA_W-1:0] rf_read_data2,
  output logic [ADDR_W-1:0] rf_write_addr,
  output logic [DATA_W-1:0] rf_write_data,
  output logic              rf_write_en,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_data,
`ifdef REGSEQ_OVF_FLAG_EN
  output logic              resp_ovf,
`endif
  output logic [ADDR_W-1:0] resp_rd
);

  typedef enum logic [2:0] {IDLE, READ, EXEC, WRITE, RESP} state_e;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_AND = 2'b10;

  state_e              state_q, state_d;
  logic [1:0]          op_q;
  logic [ADDR_W-1:0]   rd_q;
  logic [ADDR_W-1:0]   raddr1_q, raddr2_q;
  logic [ADDR_W-1:0]   waddr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic                wen_q;
  logic                resp_valid_q;
  logic [DATA_W-1:0]   resp_data_q;
  logic [ADDR_W-1:0]   resp_rd_q;

  // Results wrap modulo 2^DATA_W; MOV passes operand 1 through.
  function automatic logic [DATA_W-1:0] alu_result(input logic [1:0] op,
                                                   input logic signed [DATA_W-1:0] a,
                                                   input logic signed [DATA_W-1:0] b);
    logic [DATA_W-1:0] r;
    case (op)
      OP_ADD:  r = a + b;
      OP_SUB:  r = a - b;
      OP_AND:  r = a & b;
      default: r = a;
    endcase
    return r;
  endfunction

`ifdef REGSEQ_OVF_FLAG_EN
  logic ovf_q, resp_ovf_q;

  function automatic logic alu_ovf(input logic [1:0] op,
                                   input logic signed [DATA_W-1:0] a,
                                   input logic signed [DATA_W-1:0] b);
    logic signed [DATA_W-1:0] r;
    logic ovf;
    r   = '0;
    ovf = 1'b0;
    if (op == OP_ADD) begin
      r   = a + b;
      ovf = (a[DATA_W-1] == b[DATA_W-1]) && (r[DATA_W-1] != a[DATA_W-1]);
    end else if (op == OP_SUB) begin
      r   = a - b;
      ovf = (a[DATA_W-1] != b[DATA_W-1]) && (r[DATA_W-1] != a[DATA_W-1]);
    end
    return ovf;
  endfunction
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (cmd_valid) state_d = READ;
      READ:    state_d = EXEC;
      EXEC:    state_d = WRITE;
      WRITE:   state_d = RESP;
      RESP:    if (resp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Operands are sampled in EXEC, so rd==rs1/rs2 sees the pre-write values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q         <= '0;
      rd_q         <= '0;
      raddr1_q     <= '0;
      raddr2_q     <= '0;
      waddr_q      <= '0;
      wdata_q      <= '0;
      wen_q        <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_data_q  <= '0;
      resp_rd_q    <= '0;
`ifdef REGSEQ_OVF_FLAG_EN
      ovf_q        <= 1'b0;
      resp_ovf_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: if (cmd_valid) begin
          op_q     <= cmd_op;
          rd_q     <= cmd_rd;
          raddr1_q <= cmd_rs1;
          raddr2_q <= cmd_rs2;
        end
        EXEC: begin
          wdata_q <= alu_result(op_q, rf_read_data1, rf_read_data2);
          waddr_q <= rd_q;
          wen_q   <= (rd_q != '0);
`ifdef REGSEQ_OVF_FLAG_EN
          ovf_q   <= alu_ovf(op_q, rf_read_data1, rf_read_data2);
`endif
        end
        WRITE: begin
          wen_q        <= 1'b0;
          resp_valid_q <= 1'b1;
          resp_data_q  <= wdata_q;
          resp_rd_q    <= waddr_q;
`ifdef REGSEQ_OVF_FLAG_EN
          resp_ovf_q   <= ovf_q;
`endif
        end
        RESP: if (resp_ready) resp_valid_q <= 1'b0;
        default: ;
      endcase
    end
  end

  assign cmd_ready     = (state_q == IDLE);
  assign rf_read_addr1 = raddr1_q;
  assign rf_read_addr2 = raddr2_q;
  assign rf_write_addr = waddr_q;
  assign rf_write_data = wdata_q;
  assign rf_write_en   = wen_q;
  assign resp_valid    = resp_valid_q;
  assign resp_data     = resp_data_q;
  assign resp_rd       = resp_rd_q;
`ifdef REGSEQ_OVF_FLAG_EN
  assign resp_ovf      = resp_ovf_q;
`endif

endmodule

// File: tb/tb_regfile_op_sequencer.sv
// Randomized self-checking bench for regfile_op_sequencer with a behavioural register-file model.
module tb_regfile_op_sequencer;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              cmd_valid;
  logic              cmd_ready;
  logic [1:0]        cmd_op;
  logic [ADDR_W-1:0] cmd_rs1, cmd_rs2, cmd_rd;
  logic [ADDR_W-1:0] rf_read_addr1, rf_read_addr2, rf_write_addr;
  logic [DATA_W-1:0] rf_read_data1, rf_read_data2, rf_write_data;
  logic              rf_write_en;
  logic              resp_valid, resp_ready;
  logic [DATA_W-1:0] resp_data;
  logic [ADDR_W-1:0] resp_rd;
`ifdef REGSEQ_OVF_FLAG_EN
  logic              resp_ovf;
`endif

  int checks = 0;
  int failures = 0;

  logic [DATA_W-1:0] rf     [32];
  logic [DATA_W-1:0] ref_rf [32];
  logic              pl_we = 1'b0;
  logic [ADDR_W-1:0] pl_a = '0;
  logic [DATA_W-1:0] pl_d = '0;

  always #5 clk = ~clk;

  regfile_op_sequencer #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_rs1(cmd_rs1), .cmd_rs2(cmd_rs2), .cmd_rd(cmd_rd),
    .rf_read_addr1(rf_read_addr1), .rf_read_addr2(rf_read_addr2),
    .rf_read_data1(rf_read_data1), .rf_read_data2(rf_read_data2),
    .rf_write_addr(rf_write_addr), .rf_write_data(rf_write_data), .rf_write_en(rf_write_en),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
`ifdef REGSEQ_OVF_FLAG_EN
    .resp_ovf(resp_ovf),
`endif
    .resp_rd(resp_rd)
  );

  // Register file: combinational reads, clocked writes; preload port for the bench.
  assign rf_read_data1 = rf[rf_read_addr1];
  assign rf_read_data2 = rf[rf_read_addr2];
  always @(posedge clk) begin
    if (pl_we)            rf[pl_a] <= pl_d;
    else if (rf_write_en) rf[rf_write_addr] <= rf_write_data;
  end

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      2'd0:    return a + b;
      2'd1:    return a - b;
      2'd2:    return a & b;
      default: return a;
    endcase
  endfunction

`ifdef REGSEQ_OVF_FLAG_EN
  function automatic logic model_ovf(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, s, lim;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    lim = 64'sd2147483648;
    if (op == 2'd0)      s = sa + sb;
    else if (op == 2'd1) s = sa - sb;
    else                 return 1'b0;
    return (s >= lim) || (s < -lim);
  endfunction
`endif

  task automatic preload(input int addr, input logic [31:0] data);
    @(negedge clk);
    pl_we = 1'b1; pl_a = addr[ADDR_W-1:0]; pl_d = data;
    @(posedge clk);
    #1 pl_we = 1'b0;
    ref_rf[addr] = data;
  endtask

  task automatic check_all_zero(input string tg);
    check({tg, "_wen"},   rf_write_en, 0);
    check({tg, "_rvld"},  resp_valid, 0);
    check({tg, "_ra1"},   rf_read_addr1, 0);
    check({tg, "_ra2"},   rf_read_addr2, 0);
    check({tg, "_wa"},    rf_write_addr, 0);
    check({tg, "_wd"},    rf_write_data, 0);
    check({tg, "_rdata"}, resp_data, 0);
    check({tg, "_rrd"},   resp_rd, 0);
`ifdef REGSEQ_OVF_FLAG_EN
    check({tg, "_ovf"},   resp_ovf, 0);
`endif
  endtask

  task automatic run_cmd(input logic [1:0] op, input int rs1, input int rs2, input int rd, input int delay);
    logic [31:0] a, b, exp, wd;
    logic [4:0]  wa;
    int n, got, wcnt, wn;
    a = ref_rf[rs1]; b = ref_rf[rs2]; exp = model(op, a, b);
    @(negedge clk);
    check("cmd_ready_idle", cmd_ready, 1);
    cmd_valid = 1'b1; cmd_op = op;
    cmd_rs1 = rs1[4:0]; cmd_rs2 = rs2[4:0]; cmd_rd = rd[4:0];
    resp_ready = (delay == 0);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    n = 0; got = -1; wcnt = 0; wn = -1; wa = '0; wd = '0;
    while (got < 0 && n < 20) begin
      @(negedge clk);
      if (rf_write_en) begin wcnt++; wn = n; wa = rf_write_addr; wd = rf_write_data; end
      if (resp_valid) got = n;
      else n++;
    end
    if (got < 0) begin
      check("resp_timeout", 0, 1);
      resp_ready = 1'b0;
      return;
    end
    check("resp_latency", got, 3);
    check("wr_count", wcnt, (rd != 0) ? 1 : 0);
    if (rd != 0) begin
      check("wr_cycle", wn, 2);
      check("wr_addr", wa, rd);
      check("wr_data", wd, exp);
    end
    check("resp_data", resp_data, exp);
    check("resp_rd", resp_rd, rd);
`ifdef REGSEQ_OVF_FLAG_EN
    check("resp_ovf", resp_ovf, model_ovf(op, a, b));
`endif
    if (delay > 0) begin
      // A command offered while busy must be ignored.
      cmd_valid = 1'b1; cmd_op = 2'($urandom); cmd_rs1 = 5'($urandom);
      cmd_rs2 = 5'($urandom); cmd_rd = 5'($urandom_range(1, 31));
      for (int i = 0; i < delay; i++) begin
        @(negedge clk);
        check("hold_valid", resp_valid, 1);
        check("hold_data", resp_data, exp);
        check("hold_rd", resp_rd, rd);
        check("hold_cmd_ready", cmd_ready, 0);
        check("hold_wen", rf_write_en, 0);
      end
      cmd_valid = 1'b0;
      resp_ready = 1'b1;
    end
    @(negedge clk);
    check("post_cmd_ready", cmd_ready, 1);
    check("post_resp_valid", resp_valid, 0);
    resp_ready = 1'b0;
    if (rd != 0) ref_rf[rd] = exp;
    check("rf_dest", rf[rd], ref_rf[rd]);
    check("rf_r0", rf[0], 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a1, a2;
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = '0;
    cmd_rs1 = '0; cmd_rs2 = '0; cmd_rd = '0; resp_ready = 1'b0;
    preload(0, 32'h0);
    for (int i = 1; i < 32; i++) preload(i, $urandom);
    #1;
    check_all_zero("reset");
    check("reset_cmd_ready", cmd_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed scenarios.
    preload(3, 32'd5); preload(4, 32'd7);
    run_cmd(2'd0, 3, 4, 9, 0);
    check("t1_r9", rf[9], 32'd12);
    preload(1, 32'h3); preload(2, 32'h5);
    run_cmd(2'd1, 1, 2, 6, 0);
    check("t2a_r6", rf[6], 32'hFFFFFFFE);
    preload(1, 32'h7FFFFFFF); preload(2, 32'hFFFFFFFF);
    run_cmd(2'd1, 1, 2, 6, 1);
    check("t2b_r6", rf[6], 32'h80000000);
    preload(1, 32'h7FFFFFFF); preload(2, 32'h00000001);
    run_cmd(2'd0, 1, 2, 7, 0);
    preload(2, 32'hABCD);
    run_cmd(2'd3, 2, 1, 0, 0);
    run_cmd(2'd2, 1, 2, 8, 4);
    preload(5, 32'd10);
    run_cmd(2'd0, 5, 5, 5, 0);
    check("t5_r5", rf[5], 32'd20);
    run_cmd(2'd3, 5, 0, 11, 2);

    // Reset asserted while the write strobe is high.
    a1 = rf[10];
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 2'd0; cmd_rs1 = 5'd3; cmd_rs2 = 5'd4; cmd_rd = 5'd10;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_pre_wen", rf_write_en, 1);
    #2 rst_n = 1'b0;
    #1;
    check_all_zero("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("midrst_cmd_ready", cmd_ready, 1);
    a2 = rf[10];
    check("midrst_r10_kept", a2, a1);
    run_cmd(2'd0, 3, 4, 12, 0);

    // Randomized traffic.
    for (int k = 0; k < 40; k++) begin
      int rs1, rs2, rd;
      rs1 = $urandom_range(0, 31);
      rs2 = ($urandom_range(0, 3) == 0) ? rs1 : $urandom_range(0, 31);
      rd  = ($urandom_range(0, 3) == 0) ? rs1 : $urandom_range(0, 31);
      run_cmd(2'($urandom), rs1, rs2, rd, $urandom_range(0, 3));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
